seq_alu_flags: RTL and testbench

- Multi-cycle ALU and status-flag producer for the multi-cycle CPU datapath.
- Executes one arithmetic, logic or iterative-shift operation per start request and produces a result.
- Computes V/C/Z/S and issues a one-cycle flag load strobe that feeds the CPU's status flag register and condition-code selection logic.
- Shifts run one bit per clock, so operation latency depends on the shift amount.

---
 rtl/seq_alu_flags.sv | 227 ++++++++++++++++++++++
 tb/tb_seq_alu_flags.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_alu_flags.sv
// Multi-cycle ALU producing V/C/Z/S flags and a one-cycle flag load strobe.
// Define SEQ_ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu_flags #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             vout,
  output logic             cout,
  output logic             zout,
  output logic             sout,
  output logic             flag_ld
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

`ifdef SEQ_ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
`endif

  state_t state_reg, state_next;

  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c;
  logic             exec_v;

`ifdef SEQ_ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH:0]     asr_ext;
  logic [WIDTH-1:0]   top_mask;
  logic [WIDTH-1:0]   sign_diff;
`else
  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               shc_reg;
  logic               shv_reg;
  logic [WIDTH-1:0]   shift_work;
  logic               shift_c;
  logic               shift_v;
`endif

  // Single-cycle operations (and barrel shifts when enabled)
  always_comb begin
    sum      = '0;
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
`ifdef SEQ_ALU_FAST_SHIFT_EN
    shamt     = b_reg[SHAMT_W-1:0];
    shl_ext   = {1'b0, a_reg} << shamt;
    shr_ext   = {a_reg, 1'b0} >> shamt;
    asr_ext   = $signed({a_reg, 1'b0}) >>> shamt;
    top_mask  = ~({WIDTH{1'b1}} >> (int'(shamt) + 1));
    sign_diff = a_reg ^ {WIDTH{a_reg[MSB]}};
`endif
    case (op_reg)
      OP_ADD: begin
        sum      = {1'b0, a_reg} + {1'b0, b_reg};
        exec_res = sum[MSB:0];
        exec_c   = sum[WIDTH];
        exec_v   = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB]);
      end
      OP_SUB: begin
        sum      = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
        exec_res = sum[MSB:0];
        exec_c   = sum[WIDTH];
        exec_v   = (a_reg[MSB] != b_reg[MSB]) && (sum[MSB] != a_reg[MSB]);
      end
      OP_AND: exec_res = a_reg & b_reg;
      OP_OR:  exec_res = a_reg | b_reg;
      OP_XOR: exec_res = a_reg ^ b_reg;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      OP_SHL: begin
        exec_res = a_reg << shamt;
        exec_c   = shl_ext[WIDTH];
        // Shifts beyond the width pull zeros into the MSB as well
        exec_v   = (|(sign_diff & top_mask)) || (a_reg[MSB] && (int'(shamt) >= WIDTH));
      end
      OP_SHR: begin
        exec_res = a_reg >> shamt;
        exec_c   = shr_ext[0];
      end
      OP_ASR: begin
        exec_res = $signed(a_reg) >>> shamt;
        exec_c   = asr_ext[0];
      end
`endif
      default: ;
    endcase
  end

`ifndef SEQ_ALU_FAST_SHIFT_EN
  // One step of the iterative shifter
  always_comb begin
    shift_work = work_reg;
    shift_c    = shc_reg;
    shift_v    = shv_reg;
    case (op_reg)
      OP_SHL: begin
        shift_work = work_reg << 1;
        shift_c    = work_reg[MSB];
        shift_v    = shv_reg | (work_reg[MSB] ^ work_reg[MSB-1]);
      end
      OP_SHR: begin
        shift_work = work_reg >> 1;
        shift_c    = work_reg[0];
      end
      OP_ASR: begin
        shift_work = {work_reg[MSB], work_reg[MSB:1]};
        shift_c    = work_reg[0];
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
          state_next = EXEC;
`else
          state_next = (op >= OP_SHL) ? SHIFT : EXEC;
`endif
        end
      end
      EXEC: state_next = DONE;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      SHIFT: if (count_reg == '0) state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign flag_ld = (state_reg == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      vout      <= 1'b0;
      cout      <= 1'b0;
      zout      <= 1'b0;
      sout      <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
      work_reg  <= '0;
      count_reg <= '0;
      shc_reg   <= 1'b0;
      shv_reg   <= 1'b0;
`endif
    end else begin
      if (state_reg == IDLE && start) begin
        op_reg    <= op;
        a_reg     <= a;
        b_reg     <= b;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        work_reg  <= a;
        count_reg <= b[SHAMT_W-1:0];
        shc_reg   <= 1'b0;
        shv_reg   <= 1'b0;
`endif
      end
      if (state_reg == EXEC) begin
        result <= exec_res;
        cout   <= exec_c;
        vout   <= exec_v;
        zout   <= (exec_res == '0);
        sout   <= exec_res[MSB];
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      if (state_reg == SHIFT) begin
        if (count_reg != '0) begin
          work_reg  <= shift_work;
          count_reg <= count_reg - 1'b1;
          shc_reg   <= shift_c;
          shv_reg   <= shift_v;
        end else begin
          result <= work_reg;
          cout   <= shc_reg;
          vout   <= shv_reg;
          zout   <= (work_reg == '0);
          sout   <= work_reg[MSB];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu_flags.sv
// Directed self-checking bench for seq_alu_flags: latency, result, flags, busy/done handshake and reset abort.
module tb_seq_alu_flags;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       vout;
  logic       cout;
  logic       zout;
  logic       sout;
  logic       flag_ld;

  int tests;
  int fails;

  seq_alu_flags #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .vout(vout), .cout(cout),
    .zout(zout), .sout(sout), .flag_ld(flag_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait for done (bounded), check latency, busy cycles, result and {V,C,Z,S}.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] ai,
                        input logic [7:0] bi, input logic [7:0] exp_res, input logic [3:0] exp_vczs,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; a = ai; b = bi;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    $display("[TB] %s op=%0d a=%02h b=%02h -> result=%02h vczs=%04b lat=%0d",
             tag, o, ai, bi, result, {vout, cout, zout, sout}, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_busy);
    check({tag, " flag_ld"}, flag_ld, 1'b1);
    check({tag, " result"}, result, exp_res);
    check({tag, " vczs"}, {vout, cout, zout, sout}, exp_vczs);
    @(posedge clk); #1;
    check({tag, " done width"}, {done, flag_ld, busy}, 3'b000);
  endtask

  initial begin
    int dones;
    int sh_lat;
    tests = 0;
    fails = 0;
    start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, flag_ld, result, vout, cout, zout, sout}, 15'h0);
    @(negedge clk);
    reset = 1'b0;

    //      tag        op     a      b      res    VCZS     lat busy
    run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 2, 2);
    run_op("add_cz",  3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110, 2, 2);
    run_op("sub_eq",  3'd1, 8'h05, 8'h05, 8'h00, 4'b0110, 2, 2);
    run_op("sub_brw", 3'd1, 8'h00, 8'h01, 8'hFF, 4'b0001, 2, 2);
    run_op("sub_ovf", 3'd1, 8'h80, 8'h01, 8'h7F, 4'b1100, 2, 2);
    run_op("and",     3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 2, 2);
    run_op("or",      3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0001, 2, 2);
    run_op("xor",     3'd4, 8'hAA, 8'hAA, 8'h00, 4'b0010, 2, 2);
    run_op("shl3",    3'd5, 8'h81, 8'h03, 8'h08, 4'b1000, FAST ? 2 : 5, FAST ? 2 : 5);
    run_op("asr2",    3'd7, 8'h80, 8'h02, 8'hE0, 4'b0001, FAST ? 2 : 4, FAST ? 2 : 4);
    run_op("shr1",    3'd6, 8'h01, 8'h01, 8'h00, 4'b0110, FAST ? 2 : 3, FAST ? 2 : 3);
    run_op("asr1",    3'd7, 8'h81, 8'h09, 8'hC0, 4'b0101, FAST ? 2 : 3, FAST ? 2 : 3);
    run_op("shl0",    3'd5, 8'hC3, 8'hF8, 8'hC3, 4'b0001, 2, 2);

    // SHL 0x01 by 7 while start is re-asserted every busy cycle with an ADD
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 8'h01; b = 8'h07;
    @(posedge clk); #1;
    op = 3'd0; a = 8'h11; b = 8'h22;
    start = busy;
    dones = 0;
    sh_lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (sh_lat == 0) sh_lat = i;
      end
      start = busy;
    end
    start = 1'b0;
    $display("[TB] busy_start shl7 -> dones=%0d lat=%0d result=%02h vczs=%04b",
             dones, sh_lat, result, {vout, cout, zout, sout});
    check("busy_start dones", dones, 1);
    check("busy_start latency", sh_lat, FAST ? 2 : 9);
    check("busy_start result", result, 8'h80);
    check("busy_start vczs", {vout, cout, zout, sout}, 4'b1001);

    // Reset one cycle into a long shift aborts it with no strobe
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 8'hFF; b = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy before reset", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort outputs", {busy, done, flag_ld, result, vout, cout, zout, sout}, 15'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (flag_ld || done) dones++;
    end
    $display("[TB] reset_abort -> strobes=%0d", dones);
    check("abort strobes", dones, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 3'd4, 8'hF0, 8'hFF, 8'h0F, 4'b0000, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
